// File: rtl/ym3438_pkg.sv
// Shared definitions for the YM3438 slot-aligned blocks: slot count,
// slot-index width and the next-word select encoding.
package ym3438_pkg;

    localparam int OPN2_SLOTS = 24;

    // Index width for an arbitrary ring depth; a depth of one still needs a bit.
    function automatic int slotBits(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    localparam int OPN2_SLOT_W = slotBits(OPN2_SLOTS);

    typedef enum logic [1:0] {
        SEL_INC = 2'd0,
        SEL_WR  = 2'd1,
        SEL_CLR = 2'd2
    } next_sel_e;

endpackage

// File: rtl/ym3438_sr_tdm_if.sv
// Phase-enable, next-word control and slot-read bundle of the TDM register ring.
interface ym3438_sr_tdm_if
    import ym3438_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SLOTS = OPN2_SLOTS
);
    localparam int SLOT_W = slotBits(SLOTS);

    logic              c1;
    logic              c2;
    logic              clear;
    logic              wr_en;
    logic [WIDTH-1:0]  wr_data;
    logic              inc;
    logic [WIDTH-1:0]  rd_data;
    logic              c_out;
    logic [SLOT_W-1:0] slot;
    logic              sync;

    modport master (
        output c1, c2, clear, wr_en, wr_data, inc,
        input  rd_data, c_out, slot, sync
    );

    modport slave (
        input  c1, c2, clear, wr_en, wr_data, inc,
        output rd_data, c_out, slot, sync
    );

endinterface

// File: rtl/ym3438_slot_cnt.sv
// Modulo-SLOTS slot counter advanced by the c2 phase; sync flags slot 0.
module ym3438_slot_cnt
    import ym3438_pkg::*;
#(
    parameter int SLOTS  = OPN2_SLOTS,
    parameter int SLOT_W = slotBits(SLOTS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              adv_i,
    output logic [SLOT_W-1:0] slot_o,
    output logic              sync_o
);
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(SLOTS - 1);

    logic [SLOT_W-1:0] slot_q;
    logic [SLOT_W-1:0] slot_d;

    always_comb begin
        slot_d = slot_q;
        if (adv_i) begin
            slot_d = (slot_q == LAST_SLOT) ? '0 : slot_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_q <= '0;
        end else begin
            slot_q <= slot_d;
        end
    end

    assign slot_o = slot_q;
    assign sync_o = (slot_q == '0);

endmodule

// File: rtl/ym3438_sr_tdm.sv
// Two-phase time-division-multiplexed register ring: one word per slot,
// recirculating once per frame with per-slot clear, write and increment.
module ym3438_sr_tdm
    import ym3438_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int SLOTS    = OPN2_SLOTS,
    parameter bit SATURATE = 1'b0
) (
    input  logic           MCLK,
    input  logic           reset_n,
    ym3438_sr_tdm_if.slave bus
);
    localparam int SLOT_W = slotBits(SLOTS);

    logic [WIDTH-1:0]  head_q;
    logic [WIDTH-1:0]  head_d;
    logic [WIDTH-1:0]  ring_q [SLOTS];
    logic [WIDTH-1:0]  ring_d [SLOTS];
    logic [WIDTH-1:0]  tailWord;
    logic [WIDTH-1:0]  nextWord;
    logic [WIDTH:0]    sumFull;
    logic              nextCarry;
    next_sel_e         nextSel;
    logic [SLOT_W-1:0] slotIdx;
    logic              slotSync;

    // The tail word is the one belonging to the current slot.
    assign tailWord = ring_q[SLOTS-1];

    always_comb begin
        nextSel = SEL_INC;
        if (bus.clear) begin
            nextSel = SEL_CLR;
        end else if (bus.wr_en) begin
            nextSel = SEL_WR;
        end
    end

    // Saturation clamps only the increment path; clear and write never carry.
    always_comb begin
        sumFull   = {1'b0, tailWord} + {{WIDTH{1'b0}}, bus.inc};
        nextWord  = sumFull[WIDTH-1:0];
        nextCarry = sumFull[WIDTH];
        case (nextSel)
            SEL_CLR: begin
                nextWord  = '0;
                nextCarry = 1'b0;
            end
            SEL_WR: begin
                nextWord  = bus.wr_data;
                nextCarry = 1'b0;
            end
            default: begin
                if (SATURATE && sumFull[WIDTH]) begin
                    nextWord = '1;
                end
            end
        endcase
    end

    always_comb begin
        head_d = head_q;
        if (bus.c1) begin
            head_d = nextWord;
        end
    end

    // On a combined c1/c2 cycle the ring takes the old head while the head
    // loads a word derived from the pre-edge tail.
    always_comb begin
        ring_d = ring_q;
        if (bus.c2) begin
            ring_d[0] = head_q;
            for (int i = 1; i < SLOTS; i++) begin
                ring_d[i] = ring_q[i-1];
            end
        end
    end

    always_ff @(posedge MCLK or negedge reset_n) begin
        if (!reset_n) begin
            head_q <= '0;
            ring_q <= '{default: '0};
        end else begin
            head_q <= head_d;
            ring_q <= ring_d;
        end
    end

    ym3438_slot_cnt #(
        .SLOTS  (SLOTS),
        .SLOT_W (SLOT_W)
    ) u_slot_cnt (
        .clk    (MCLK),
        .rst_n  (reset_n),
        .adv_i  (bus.c2),
        .slot_o (slotIdx),
        .sync_o (slotSync)
    );

    assign bus.rd_data = tailWord;
    assign bus.c_out   = nextCarry & reset_n;
    assign bus.slot    = slotIdx;
    assign bus.sync    = slotSync;

endmodule
